move_sched: RTL and testbench

Move scheduler for the maze solver. It accepts one abstract move command at a time (forward, left, right, U-turn) and converts it into a degree count and per-wheel direction. It launches both wheel step controllers with a single shared enable, then waits for both wheels to finish and a settle interval to elapse before reporting done. It sits between the maze-navigation FSM and the two per-wheel step controllers and PWM drivers.

---
 rtl/move_sched.sv | 161 ++++++++++++++++
 tb/tb_move_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/move_sched.sv
// move_sched: turns one abstract maze move into a shared step-controller launch, then waits
// for both wheels plus a settle interval before pulsing done. Watchdog/FAULT via MOVE_TIMEOUT_EN.
module move_sched #(
    parameter logic [15:0] FWD_DEGS       = 16'd360,
    parameter logic [15:0] TURN_DEGS      = 16'd180,
    parameter logic [15:0] SETTLE_CYCLES  = 16'd8000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd8000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd,
    output logic        cmd_ready,
    input  logic        motor_en_l,
    input  logic        motor_en_r,
    input  logic        fault_clr,
    output logic        step_en,
    output logic [15:0] step_ndegs,
    output logic        dir_l,
    output logic        dir_r,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic        step_abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_SETTLE
`ifdef MOVE_TIMEOUT_EN
        , S_FAULT
`endif
    } state_t;

    localparam logic [16:0] UTURN_SUM  = {1'b0, TURN_DEGS} + {1'b0, TURN_DEGS};
    localparam logic [15:0] UTURN_DEGS = UTURN_SUM[16] ? 16'hFFFF : UTURN_SUM[15:0];

    state_t      state_q;
    logic [15:0] ndegs_q;
    logic [15:0] settle_q;
    logic        dir_l_q;
    logic        dir_r_q;
    logic        seen_l_q;
    logic        seen_r_q;
    logic        done_q;
    logic        run_exit;

    // Sticky seen flags catch the single-cycle motor_en pulse of a zero-degree move.
    assign run_exit = seen_l_q & seen_r_q & ~motor_en_l & ~motor_en_r;

`ifdef MOVE_TIMEOUT_EN
    logic [23:0] wdog_q;
    logic        wdog_hit;
    // wdog_q holds cycles elapsed since LAUNCH, so the trip lands exactly TIMEOUT_CYCLES after it.
    assign wdog_hit = ({1'b0, wdog_q} + 25'd1) >= {1'b0, TIMEOUT_CYCLES};
`else
    logic unused_cfg;
    assign unused_cfg = fault_clr ^ (^TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ndegs_q  <= '0;
            settle_q <= '0;
            dir_l_q  <= 1'b1;
            dir_r_q  <= 1'b1;
            seen_l_q <= 1'b0;
            seen_r_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            wdog_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd)
                            2'd0: begin ndegs_q <= FWD_DEGS;   dir_l_q <= 1'b1; dir_r_q <= 1'b1; end
                            2'd1: begin ndegs_q <= TURN_DEGS;  dir_l_q <= 1'b0; dir_r_q <= 1'b1; end
                            2'd2: begin ndegs_q <= TURN_DEGS;  dir_l_q <= 1'b1; dir_r_q <= 1'b0; end
                            default: begin ndegs_q <= UTURN_DEGS; dir_l_q <= 1'b0; dir_r_q <= 1'b1; end
                        endcase
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    seen_l_q <= 1'b0;
                    seen_r_q <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
                    wdog_q   <= 24'd1;
`endif
                    state_q  <= S_RUN;
                end
                S_RUN: begin
                    seen_l_q <= seen_l_q | motor_en_l;
                    seen_r_q <= seen_r_q | motor_en_r;
`ifdef MOVE_TIMEOUT_EN
                    wdog_q   <= wdog_q + 24'd1;
`endif
                    if (run_exit) begin
                        if (SETTLE_CYCLES != '0) begin
                            settle_q <= SETTLE_CYCLES;
                            state_q  <= S_SETTLE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
`ifdef MOVE_TIMEOUT_EN
                    else if (wdog_hit) begin
                        state_q <= S_FAULT;
                    end
`endif
                end
                S_SETTLE: begin
                    settle_q <= settle_q - 16'd1;
`ifdef MOVE_TIMEOUT_EN
                    wdog_q   <= wdog_q + 24'd1;
`endif
                    if (settle_q == 16'd1) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
`ifdef MOVE_TIMEOUT_EN
                    else if (wdog_hit) begin
                        state_q <= S_FAULT;
                    end
`endif
                end
`ifdef MOVE_TIMEOUT_EN
                S_FAULT: begin
                    if (fault_clr) begin
                        state_q <= S_IDLE;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign step_en    = (state_q == S_LAUNCH);
    assign step_ndegs = ndegs_q;
    assign dir_l      = dir_l_q;
    assign dir_r      = dir_r_q;
    assign done       = done_q;
`ifdef MOVE_TIMEOUT_EN
    assign fault      = (state_q == S_FAULT);
    assign step_abort = (state_q == S_FAULT);
`else
    assign fault      = 1'b0;
    assign step_abort = 1'b0;
`endif

endmodule

// File: tb/tb_move_sched.sv
// Randomized bench for move_sched: two instances (long settle / zero settle) against a cycle-level move model.
`timescale 1ns/1ps
module tb_move_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        motor_en_l;
    logic        motor_en_r;
    logic        fault_clr;

    logic        rdy_a, sen_a, dl_a, dr_a, busy_a, done_a, flt_a, abt_a;
    logic        rdy_b, sen_b, dl_b, dr_b, busy_b, done_b, flt_b, abt_b;
    logic [15:0] nd_a, nd_b;

    logic        o_ready, o_step_en, o_dir_l, o_dir_r, o_busy, o_done, o_fault, o_abort;
    logic [15:0] o_ndegs;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    move_sched #(.TURN_DEGS(16'hF000), .SETTLE_CYCLES(16'd8000)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid & ~sel), .cmd(cmd), .cmd_ready(rdy_a),
        .motor_en_l(motor_en_l), .motor_en_r(motor_en_r), .fault_clr(fault_clr),
        .step_en(sen_a), .step_ndegs(nd_a), .dir_l(dl_a), .dir_r(dr_a),
        .busy(busy_a), .done(done_a), .fault(flt_a), .step_abort(abt_a)
    );

    move_sched #(.SETTLE_CYCLES(16'd0), .TIMEOUT_CYCLES(24'd1000)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid & sel), .cmd(cmd), .cmd_ready(rdy_b),
        .motor_en_l(motor_en_l), .motor_en_r(motor_en_r), .fault_clr(fault_clr),
        .step_en(sen_b), .step_ndegs(nd_b), .dir_l(dl_b), .dir_r(dr_b),
        .busy(busy_b), .done(done_b), .fault(flt_b), .step_abort(abt_b)
    );

    assign o_ready   = sel ? rdy_b  : rdy_a;
    assign o_step_en = sel ? sen_b  : sen_a;
    assign o_ndegs   = sel ? nd_b   : nd_a;
    assign o_dir_l   = sel ? dl_b   : dl_a;
    assign o_dir_r   = sel ? dr_b   : dr_a;
    assign o_busy    = sel ? busy_b : busy_a;
    assign o_done    = sel ? done_b : done_a;
    assign o_fault   = sel ? flt_b  : flt_a;
    assign o_abort   = sel ? abt_b  : abt_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode straight from the move table; U-turn saturates at 16 bits.
    function automatic logic [17:0] exp_move(input logic [1:0] c, input int unsigned turn);
        int unsigned d;
        logic xl, xr;
        case (c)
            2'd0:    d = 360;
            2'd1,
            2'd2:    d = turn;
            default: d = (2 * turn > 65535) ? 65535 : 2 * turn;
        endcase
        xl = (c == 2'd0) || (c == 2'd2);
        xr = (c != 2'd2);
        return {xl, xr, d[15:0]};
    endfunction

    // Entered at the negedge of the accept cycle (t=0); returns at the negedge of the done cycle.
    task automatic run_move(input logic [1:0] c, input int unsigned s, input int unsigned dl,
                            input int unsigned dr, input bit hold, input bit chained,
                            input int unsigned settle, input int unsigned turn);
        int unsigned f, tdone;
        logic [17:0] xm;
        f     = s + ((dl > dr) ? dl : dr);
        tdone = f + settle + 1;
        xm    = exp_move(c, turn);
        for (int unsigned t = 0; t <= tdone; t++) begin
            check("ready", o_ready, (t == 0) || (t == tdone));
            check("step_en", o_step_en, (t == 1));
            check("busy", o_busy, (t != 0) && (t != tdone));
            check("done", o_done, (t == tdone) || (t == 0 && chained));
            check("fault", o_fault, 1'b0);
            check("abort", o_abort, 1'b0);
            if (t >= 1) begin
                check("ndegs", o_ndegs, xm[15:0]);
                check("dir_l", o_dir_l, xm[17]);
                check("dir_r", o_dir_r, xm[16]);
            end
            cmd_valid  = (t == 0) || hold;
            if (t == 0) cmd = c;
            motor_en_l = (t >= s) && (t < s + dl);
            motor_en_r = (t >= s) && (t < s + dr);
            fault_clr  = ($urandom_range(0, 7) == 0);
            if (t < tdone) @(negedge clk);
        end
    endtask

    task automatic go_idle(input int unsigned n);
        cmd_valid  = 1'b0;
        motor_en_l = 1'b0;
        motor_en_r = 1'b0;
        fault_clr  = 1'b0;
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, o_ready, 1'b1);
        check({tag, "_step_en"}, o_step_en, 1'b0);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_done"}, o_done, 1'b0);
        check({tag, "_fault"}, o_fault, 1'b0);
        check({tag, "_abort"}, o_abort, 1'b0);
        check({tag, "_ndegs"}, o_ndegs, 16'd0);
        check({tag, "_dirs"}, {o_dir_l, o_dir_r}, 2'b11);
    endtask

    initial begin
        bit chained;
        bit hold;
        int unsigned gap, kind, dl, dr;
        rst_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd = 2'd0;
        motor_en_l = 1'b0; motor_en_r = 1'b0; fault_clr = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst_a");
        sel = 1'b1; #1;
        check_reset_vals("rst_b");
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Long-settle instance: full-length forward plus each turn type.
        run_move(2'd0, 2, 360, 360, 1'b0, 1'b0, 8000, 32'hF000);
        go_idle(3);
        run_move(2'd3, 3, 30, 40, 1'b0, 1'b0, 8000, 32'hF000);
        go_idle(2);
        run_move(2'd1, 2, 1, 1, 1'b0, 1'b0, 8000, 32'hF000);
        go_idle(1);
        run_move(2'd2, 4, 50, 150, 1'b0, 1'b0, 8000, 32'hF000);
        go_idle(3);

        // Zero-settle instance: fixed corner cases, then random traffic.
        sel = 1'b1;
        @(negedge clk);
        run_move(2'd0, 2, 20, 120, 1'b0, 1'b0, 0, 180);
        go_idle(2);
        run_move(2'd1, 2, 1, 1, 1'b1, 1'b0, 0, 180);
        run_move(2'd3, 3, 1, 1, 1'b1, 1'b1, 0, 180);
        run_move(2'd2, 2, 7, 5, 1'b0, 1'b1, 0, 180);
        chained = 1'b1;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0: begin dl = 1; dr = 1; end
                1: begin dl = 20; dr = 120; end
                2: begin dl = 120; dr = 20; end
                default: begin dl = $urandom_range(1, 40); dr = $urandom_range(1, 40); end
            endcase
            hold = ($urandom_range(0, 3) == 0) && (i != 39);
            run_move(2'($urandom_range(0, 3)), $urandom_range(2, 4), dl, dr, hold, chained, 0, 180);
            gap = hold ? 0 : $urandom_range(0, 2);
            chained = (gap == 0);
            if (gap != 0) go_idle(gap);
        end
        if (chained) go_idle(1);
        go_idle(2);

        // Asynchronous reset in the middle of RUN.
        cmd_valid = 1'b1; cmd = 2'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        motor_en_l = 1'b1; motor_en_r = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", o_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        motor_en_l = 1'b0; motor_en_r = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", o_ready, 1'b1);
        go_idle(2);

`ifdef MOVE_TIMEOUT_EN
        // Left wheel stuck busy: fault exactly 1000 cycles after LAUNCH.
        cmd_valid = 1'b1; cmd = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("to_launch", o_step_en, 1'b1);
        for (int t = 2; t <= 1001; t++) begin
            @(negedge clk);
            motor_en_l = 1'b1;
            if (t == 1000) check("to_early", o_fault, 1'b0);
        end
        check("to_fault", o_fault, 1'b1);
        check("to_abort", o_abort, 1'b1);
        check("to_ready", o_ready, 1'b0);
        check("to_done", o_done, 1'b0);
        repeat (3) @(negedge clk);
        check("to_hold", o_fault, 1'b1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        motor_en_l = 1'b0;
        check("clr_fault", o_fault, 1'b0);
        check("clr_abort", o_abort, 1'b0);
        check("clr_ready", o_ready, 1'b1);
        check("clr_done", o_done, 1'b0);
        go_idle(2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
